// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds FSM states, access sizes, port IDs and the request check.
package dmem_arbiter_pkg;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_e;

  localparam logic [2:0] FUNCT3_WORD  = 3'b010;
  localparam logic [2:0] FUNCT3_DWORD = 3'b011;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        err;
    logic        id;
  } acc_t;

  // Range check in 65 bits so a huge address cannot wrap into range.
  function automatic logic req_bad(
    input logic [2:0]  f3,
    input logic [63:0] addr,
    input logic [64:0] mem_bytes
  );
    logic [64:0] size;
    logic        bad;
    size = (f3 == FUNCT3_DWORD) ? 65'd8 : 65'd4;
    bad  = (f3 != FUNCT3_WORD) && (f3 != FUNCT3_DWORD);
    if ((addr & (size[63:0] - 64'd1)) != 64'd0) bad = 1'b1;
    if (({1'b0, addr} + size) > mem_bytes) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Fixed core priority, overridden once the debug port has starved.
module dmem_arb_pick
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CW           = 3
) (
  input  logic          core_req,
  input  logic          dbg_req,
  input  logic [CW-1:0] starve_cnt,
  output logic          winner
);

  always_comb begin
    winner = PORT_CORE;
    if (dbg_req && (!core_req || starve_cnt == CW'(STARVE_LIMIT)))
      winner = PORT_DBG;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: grant in IDLE, access in ACCESS,
// registered response to the winner one cycle later.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MEM_BYTES    = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [2:0]  core_funct3,
  input  logic [63:0] core_addr,
  input  logic [63:0] core_wdata,
  output logic        core_gnt,
  output logic        core_rvalid,
  output logic [63:0] core_rdata,
  output logic        core_err,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [2:0]  dbg_funct3,
  input  logic [63:0] dbg_addr,
  input  logic [63:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [63:0] dbg_rdata,
  output logic        dbg_err,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  output logic [2:0]  mem_funct3,
  input  logic [63:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  state_e        state_q, state_d;
  acc_t          acc_q, acc_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          core_rvalid_q, core_rvalid_d;
  logic          core_err_q, core_err_d;
  logic [63:0]   core_rdata_q, core_rdata_d;
  logic          dbg_rvalid_q, dbg_rvalid_d;
  logic          dbg_err_q, dbg_err_d;
  logic [63:0]   dbg_rdata_q, dbg_rdata_d;
  logic          win, idle, act;
  logic [63:0]   rsp;

  dmem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CW          (CW)
  ) u_pick (
    .core_req  (core_req),
    .dbg_req   (dbg_req),
    .starve_cnt(starve_q),
    .winner    (win)
  );

  always_comb begin
    idle     = reset_n && (state_q == S_IDLE);
    core_gnt = idle && core_req && (win == PORT_CORE);
    dbg_gnt  = idle && dbg_req && (win == PORT_DBG);
    state_d  = state_q;
    acc_d    = acc_q;
    starve_d = starve_q;
    if (state_q == S_ACCESS) state_d = S_IDLE;
    else if (core_gnt || dbg_gnt) state_d = S_ACCESS;
    if (core_gnt)
      acc_d = '{we: core_we, funct3: core_funct3,
                addr: core_addr, wdata: core_wdata,
                err: req_bad(core_funct3, core_addr, 65'(MEM_BYTES)),
                id: PORT_CORE};
    else if (dbg_gnt)
      acc_d = '{we: dbg_we, funct3: dbg_funct3,
                addr: dbg_addr, wdata: dbg_wdata,
                err: req_bad(dbg_funct3, dbg_addr, 65'(MEM_BYTES)),
                id: PORT_DBG};
    if (!dbg_req || dbg_gnt) starve_d = '0;
    else if (core_gnt && starve_q != CW'(STARVE_LIMIT))
      starve_d = starve_q + CW'(1);

    // Errored requests never reach memory.
    act        = (state_q == S_ACCESS) && !acc_q.err;
    mem_addr   = act ? acc_q.addr : 64'd0;
    mem_wdata  = act ? acc_q.wdata : 64'd0;
    mem_funct3 = act ? acc_q.funct3 : 3'd0;
    mem_write  = act && acc_q.we;
    mem_read   = act && !acc_q.we;

    rsp = 64'd0;
    if (act && !acc_q.we)
      rsp = (acc_q.funct3 == FUNCT3_WORD) ?
            {32'd0, mem_rdata[31:0]} : mem_rdata;
    core_rvalid_d = 1'b0;
    core_err_d    = 1'b0;
    core_rdata_d  = 64'd0;
    dbg_rvalid_d  = 1'b0;
    dbg_err_d     = 1'b0;
    dbg_rdata_d   = 64'd0;
    if (state_q == S_ACCESS) begin
      if (acc_q.id == PORT_CORE) begin
        core_rvalid_d = 1'b1;
        core_err_d    = acc_q.err;
        core_rdata_d  = rsp;
      end else begin
        dbg_rvalid_d = 1'b1;
        dbg_err_d    = acc_q.err;
        dbg_rdata_d  = rsp;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      acc_q         <= '0;
      starve_q      <= '0;
      core_rvalid_q <= 1'b0;
      core_err_q    <= 1'b0;
      core_rdata_q  <= 64'd0;
      dbg_rvalid_q  <= 1'b0;
      dbg_err_q     <= 1'b0;
      dbg_rdata_q   <= 64'd0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      starve_q      <= starve_d;
      core_rvalid_q <= core_rvalid_d;
      core_err_q    <= core_err_d;
      core_rdata_q  <= core_rdata_d;
      dbg_rvalid_q  <= dbg_rvalid_d;
      dbg_err_q     <= dbg_err_d;
      dbg_rdata_q   <= dbg_rdata_d;
    end
  end

  assign core_rvalid = core_rvalid_q;
  assign core_err    = core_err_q;
  assign core_rdata  = core_rdata_q;
  assign dbg_rvalid  = dbg_rvalid_q;
  assign dbg_err     = dbg_err_q;
  assign dbg_rdata   = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a byte-array memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        core_req, core_we, core_gnt, core_rvalid, core_err;
  logic [2:0]  core_funct3;
  logic [63:0] core_addr, core_wdata, core_rdata;
  logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid, dbg_err;
  logic [2:0]  dbg_funct3;
  logic [63:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read;
  logic [2:0]  mem_funct3;

  typedef struct {
    logic        err;
    logic [63:0] rdata;
    int          due;
  } exp_t;

  exp_t core_q[$];
  exp_t dbg_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [7:0] mem [0:63];

  dmem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .core_req(core_req), .core_we(core_we),
    .core_funct3(core_funct3), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .core_err(core_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_funct3(dbg_funct3), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .dbg_err(dbg_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always_comb begin
    mem_rdata = 64'd0;
    for (int i = 0; i < 8; i++)
      mem_rdata[i*8 +: 8] = mem[mem_addr[5:0] + 6'(i)];
  end

  always @(posedge clk)
    if (mem_write === 1'b1)
      for (int i = 0; i < 8; i++)
        if (i < 4 || mem_funct3 == 3'b011)
          mem[mem_addr[5:0] + 6'(i)] = mem_wdata[i*8 +: 8];

  always @(negedge clk) begin
    exp_t e;
    if (core_rvalid === 1'b1) begin
      vectors++;
      if (core_q.size() == 0) begin
        miscompares++;
        $display("FAIL core_rsp unexpected: err=%0b rdata=%h cyc=%0d",
                 core_err, core_rdata, cyc);
      end else begin
        e = core_q.pop_front();
        if (core_err !== e.err || core_rdata !== e.rdata || cyc != e.due) begin
          miscompares++;
          $display("FAIL core_rsp got err=%0b rdata=%h cyc=%0d want err=%0b rdata=%h cyc=%0d",
                   core_err, core_rdata, cyc, e.err, e.rdata, e.due);
        end
      end
    end
    if (dbg_rvalid === 1'b1) begin
      vectors++;
      if (dbg_q.size() == 0) begin
        miscompares++;
        $display("FAIL dbg_rsp unexpected: err=%0b rdata=%h cyc=%0d",
                 dbg_err, dbg_rdata, cyc);
      end else begin
        e = dbg_q.pop_front();
        if (dbg_err !== e.err || dbg_rdata !== e.rdata || cyc != e.due) begin
          miscompares++;
          $display("FAIL dbg_rsp got err=%0b rdata=%h cyc=%0d want err=%0b rdata=%h cyc=%0d",
                   dbg_err, dbg_rdata, cyc, e.err, e.rdata, e.due);
        end
      end
    end
  end

  task automatic drive(input logic port, input logic req, input logic we,
                       input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wd);
    if (port) begin
      dbg_req = req; dbg_we = we; dbg_funct3 = f3;
      dbg_addr = addr; dbg_wdata = wd;
    end else begin
      core_req = req; core_we = we; core_funct3 = f3;
      core_addr = addr; core_wdata = wd;
    end
  endtask

  task automatic push(input logic port, input logic err,
                      input logic [63:0] rd);
    exp_t e;
    e.err = err; e.rdata = rd; e.due = cyc + 2;
    if (port) dbg_q.push_back(e);
    else core_q.push_back(e);
  endtask

  // Request, wait (bounded) for grant, then sample the ACCESS-cycle bus.
  task automatic issue(input logic port, input logic we,
                       input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wd, input logic xerr,
                       input logic [63:0] xrd, output logic [1:0] wr_rd,
                       output logic [63:0] m_addr, output logic [63:0] m_wd);
    bit got = 0;
    @(posedge clk) #1;
    drive(port, 1'b1, we, f3, addr, wd);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((port ? dbg_gnt : core_gnt) === 1'b1) got = 1;
      else @(posedge clk) #1;
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL grant_timeout port=%0d addr=%h got=none want=gnt",
               port, addr);
    end else push(port, xerr, xrd);
    @(posedge clk) #1;
    drive(port, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
    @(negedge clk);
    wr_rd = {mem_write, mem_read};
    m_addr = mem_addr;
    m_wd = mem_wdata;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 3'b011, 64'd8, 64'd0);
    drive(1'b1, 1'b1, 1'b0, 3'b011, 64'd8, 64'd0);
    @(negedge clk);
    vectors++;
    if ({core_gnt, dbg_gnt} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_gnt got=%b want=00", {core_gnt, dbg_gnt});
    end
    vectors++;
    if ({core_rvalid, dbg_rvalid, core_err, dbg_err} !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_rsp got=%b want=0000",
               {core_rvalid, dbg_rvalid, core_err, dbg_err});
    end
    vectors++;
    if (core_rdata !== 64'd0 || dbg_rdata !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_rdata got=%h/%h want=0/0", core_rdata, dbg_rdata);
    end
    vectors++;
    if ({mem_write, mem_read, mem_funct3, mem_addr, mem_wdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_mem got w=%b r=%b a=%h want all 0",
               mem_write, mem_read, mem_addr);
    end
    drive(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
    reset_n = 1'b1;
  endtask

  task automatic test_core_load();
    logic [1:0] wr; logic [63:0] a, wd;
    logic [63:0] pat;
    pat = 64'h8762DFC2_05111030;
    for (int i = 0; i < 8; i++) mem[8+i] = pat[i*8 +: 8];
    issue(1'b0, 1'b0, 3'b011, 64'd8, 64'd0, 1'b0, pat, wr, a, wd);
    vectors++;
    if (wr !== 2'b01 || a !== 64'd8) begin
      miscompares++;
      $display("FAIL core_ld_bus got wr_rd=%b addr=%h want 01/8", wr, a);
    end
  endtask

  task automatic test_dbg_store_core_load();
    logic [1:0] wr; logic [63:0] a, wd;
    for (int i = 40; i < 48; i++) mem[i] = 8'hAA;
    issue(1'b1, 1'b1, 3'b010, 64'd40, 64'h55555555_DEADBEEF,
          1'b0, 64'd0, wr, a, wd);
    vectors++;
    if (wr !== 2'b10 || wd !== 64'h55555555_DEADBEEF) begin
      miscompares++;
      $display("FAIL dbg_sw_bus got wr_rd=%b wdata=%h want 10/55555555deadbeef",
               wr, wd);
    end
    issue(1'b0, 1'b0, 3'b010, 64'd40, 64'd0, 1'b0,
          64'h00000000_DEADBEEF, wr, a, wd);
    issue(1'b0, 1'b0, 3'b011, 64'd40, 64'd0, 1'b0,
          64'hAAAAAAAA_DEADBEEF, wr, a, wd);
  endtask

  task automatic test_errors();
    logic [1:0] wr; logic [63:0] a, wd;
    logic [2:0] f3 [7];
    logic [63:0] ad [7];
    logic we [7];
    logic xe [7];
    logic [63:0] xr [7];
    for (int i = 0; i < 8; i++) mem[56+i] = 8'(i + 1);
    f3 = '{3'b011, 3'b010, 3'b000, 3'b011, 3'b011, 3'b010, 3'b011};
    ad = '{64'd60, 64'd2, 64'd0, 64'hFFFFFFFF_FFFFFFF8, 64'd64,
           64'd60, 64'd56};
    we = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    xe = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    xr = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd0,
           64'h00000000_08070605, 64'h08070605_04030201};
    for (int i = 0; i < 7; i++) begin
      issue(1'b0, we[i], f3[i], ad[i], 64'h1111, xe[i], xr[i], wr, a, wd);
      vectors++;
      if (wr !== (xe[i] ? 2'b00 : 2'b01)) begin
        miscompares++;
        $display("FAIL err_bus[%0d] got wr_rd=%b want %b",
                 i, wr, xe[i] ? 2'b00 : 2'b01);
      end
    end
  endtask

  task automatic test_starvation();
    string got;
    int n;
    got = "";
    n = 0;
    for (int i = 0; i < 8; i++) mem[i] = 8'hA0 + 8'(i);
    @(posedge clk) #1;
    drive(1'b0, 1'b1, 1'b0, 3'b011, 64'd0, 64'd0);
    drive(1'b1, 1'b1, 1'b0, 3'b011, 64'd8, 64'd0);
    for (int c = 0; c < 40 && n < 10; c++) begin
      @(negedge clk);
      if (core_gnt === 1'b1 && dbg_gnt === 1'b1) got = {got, "B"};
      if (core_gnt === 1'b1) begin
        got = {got, "C"}; n++;
        push(1'b0, 1'b0, 64'hA7A6A5A4_A3A2A1A0);
      end else if (dbg_gnt === 1'b1) begin
        got = {got, "D"}; n++;
        push(1'b1, 1'b0, 64'h8762DFC2_05111030);
      end
    end
    @(posedge clk) #1;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
    vectors++;
    if (got != "CCCCDCCCCD") begin
      miscompares++;
      $display("FAIL starve_order got=%s want=CCCCDCCCCD", got);
    end
  endtask

  task automatic test_reset_mid_access();
    repeat (3) @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 1'b1, 3'b011, 64'd16, 64'h0123456789ABCDEF);
    @(negedge clk);
    vectors++;
    if (core_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre_gnt got=%b want=1", core_gnt);
    end
    @(posedge clk) #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({mem_write, mem_read, mem_addr, core_gnt, core_rvalid} !== '0) begin
      miscompares++;
      $display("FAIL rst_async got w=%b r=%b a=%h gnt=%b rv=%b want all 0",
               mem_write, mem_read, mem_addr, core_gnt, core_rvalid);
    end
    drive(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk) #1;
    drive(1'b0, 1'b1, 1'b0, 3'b011, 64'd8, 64'd0);
    @(negedge clk);
    vectors++;
    if (core_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_first_gnt got=%b want=1", core_gnt);
    end else push(1'b0, 1'b0, 64'h8762DFC2_05111030);
    @(posedge clk) #1;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && (core_q.size() + dbg_q.size()) != 0; i++)
      @(posedge clk);
    @(posedge clk);
    vectors++;
    if (core_q.size() + dbg_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending core=%0d dbg=%0d want 0/0",
               core_q.size(), dbg_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    test_reset();
    test_core_load();
    test_dbg_store_core_load();
    test_errors();
    test_starvation();
    drain();
    test_reset_mid_access();
    drain();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The parameters SHALL be: MEM_BYTES, default 64, data memory size in bytes; STARVE_LIMIT, default 4, consecutive lost arbitrations before the debug port is forced to win.
REQ-002 The ports SHALL be:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- core_req  in  1  pipeline MEM-stage request; held with its payload stable until core_gnt.
- core_we  in  1  1 = store, 0 = load.
- core_funct3  in  3  access size: 010 = word, 011 = doubleword.
- core_addr  in  64  byte address.
- core_wdata  in  64  store data.
- core_gnt  out  1  request accepted this cycle.
- core_rvalid  out  1  one-cycle response pulse.
- core_rdata  out  64  load data, valid with core_rvalid.
- core_err  out  1  request rejected, valid with core_rvalid.
- dbg_req, dbg_we, dbg_funct3, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err  SHALL match the core_* ports for the debug/loader port.
- mem_addr  out  64  to data memory.
- mem_wdata  out  64  to data memory.
- mem_write  out  1  to data memory (MemWrite).
- mem_read  out  1  to data memory (MemRead).
- mem_funct3  out  3  to data memory.
- mem_rdata  in  64  combinational read data from data memory.

Function
REQ-003 The FSM SHALL have states IDLE and ACCESS; gnt SHALL only assert in IDLE, at most one gnt per cycle.
REQ-004 IDLE -> ACCESS SHALL occur on any grant; ACCESS -> IDLE SHALL occur unconditionally after one cycle, giving a throughput of one access per 2 cycles.
REQ-005 On grant, the arbiter SHALL latch we/funct3/addr/wdata and the winner ID; in ACCESS it SHALL drive the mem_* outputs from the latch (mem_write = we, mem_read = !we); in IDLE all mem_* outputs SHALL be 0.
REQ-006 Latency: gnt in cycle T, memory access in T+1 (store committed at the T+1→T+2 edge), winner rvalid plus registered rdata in T+2; the response goes only to the winner.
REQ-007 Arbitration: core wins when both request, unless starve_cnt == STARVE_LIMIT, in which case dbg wins.
REQ-008 starve_cnt SHALL increment (saturating) when dbg_req is high and core is granted, and SHALL clear on a dbg grant or when dbg_req is low.
REQ-009 A request SHALL be flagged as an error when any of the following holds: funct3 is not 010 or 011; addr is not aligned to the access size; or addr + size > MEM_BYTES, computed in 65-bit arithmetic so that no wrap occurs.
REQ-010 An error request SHALL still be granted, SHALL NOT touch memory (mem_* held 0 in its ACCESS cycle), and SHALL return rvalid=1, err=1, rdata=0 at T+2.
REQ-011 Store responses SHALL return rvalid=1, err=0, rdata=0; load word rdata SHALL be the zero-extended 32-bit value.
REQ-012 rvalid, err and rdata SHALL be registered; between responses, rdata SHALL hold 0.
REQ-013 When a new request is granted in the same cycle that a previous response is pulsed (T+2), both SHALL occur.

Reset
REQ-014 Asserting reset_n low SHALL immediately force: FSM=IDLE, starve_cnt=0, all gnt/rvalid/err=0, all rdata=0, all mem_* outputs=0.
REQ-015 Reset during ACCESS SHALL abort the access with no response; a store whose commit edge coincides with reset assertion has undefined memory contents.
REQ-016 After reset_n deasserts, the first grant SHALL be possible in the first clock cycle.

Structure
REQ-017 A shared package SHALL hold the FSM state enum, the FUNCT3_WORD/FUNCT3_DWORD constants, and the port-ID encoding (PORT_CORE=0, PORT_DBG=1).
REQ-018 The priority/starvation logic SHALL be one sub-module, dmem_arb_pick (inputs: both reqs plus starve_cnt; output: winner).

Verification
REQ-019 Core load: core ld at addr 8 with memory bytes 8..15 = 0x30,0x10,0x11,0x05,0xC2,0xDF,0x62,0x87 -> core_gnt at T, core_rvalid at T+2, core_rdata=0x8762DFC2_05111030, core_err=0.
REQ-020 Debug store then core load: dbg sw 0xDEADBEEF at addr 40 -> dbg ack at T+2; then core lw at 40 -> rdata=0x00000000_DEADBEEF.
REQ-021 Starvation: both ports request continuously -> core granted 4 times, then dbg granted once, repeating.
REQ-022 Errors: core ld at addr 60 (range), lw at addr 2 (alignment), funct3=000 -> each gives rvalid, err=1, rdata=0, mem_write/mem_read never asserted.
REQ-023 Reset: reset_n pulsed low mid-ACCESS -> all outputs 0 asynchronously, no rvalid, next request granted in the first cycle after release.
